fill_datapath: RTL and testbench

- Datapath stage driven by the VGA fill controller. It consumes the controller's en_counter, y_reset and s, and produces the frame-complete flag f.
- Walks every pixel of the frame buffer in raster order and issues one write per pixel to the frame-buffer write port.
- Write data is either an 8-bar colour test pattern (s=0, draw) or black (s=1, clear).
- Write-port backpressure is honoured with a valid/ready handshake.

---
 rtl/fill_datapath.sv | 120 ++++++++++++
 tb/tb_fill_datapath.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fill_datapath.sv
// fill_datapath: raster-order frame-buffer fill stage for the VGA fill controller.
// Issues one write per pixel (colour-bar test pattern or black) over a
// valid/ready write port and raises f once the last pixel has been accepted.
module fill_datapath #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_counter,
  input  logic               y_reset,
  input  logic               s,
  input  logic               wr_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               f
);

  localparam int BAR_W = H_RES / 8;
  localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int C_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(BAR_W - 1);

  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr_cnt;
  logic [2:0]        bar;
  logic [C_W-1:0]    col;
  logic              issued_all;

  logic load;
  logic issue;

  // Eight-entry RGB444 colour-bar table.
  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 12'hFFF;
      3'd1:    bar_color = 12'hFF0;
      3'd2:    bar_color = 12'h0FF;
      3'd3:    bar_color = 12'h0F0;
      3'd4:    bar_color = 12'hF0F;
      3'd5:    bar_color = 12'hF00;
      3'd6:    bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction

  // Output register may reload when empty or when its write is being accepted.
  always_comb begin
    load  = !wr_en || wr_ready;
    issue = load && en_counter && !issued_all && !f;
  end

  // Pixel walk, output register and frame-complete flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      addr_cnt   <= '0;
      bar        <= '0;
      col        <= '0;
      issued_all <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      f          <= 1'b0;
    end else if (y_reset) begin
      // Restart drops any pending write, even one being accepted this cycle.
      x          <= '0;
      y          <= '0;
      addr_cnt   <= '0;
      bar        <= '0;
      col        <= '0;
      issued_all <= 1'b0;
      wr_en      <= 1'b0;
      f          <= 1'b0;
    end else begin
      // Once issued_all is set the only write still in flight is the last pixel.
      if (wr_en && wr_ready && issued_all) begin
        f <= 1'b1;
      end
      if (load) begin
        if (issue) begin
          wr_en    <= 1'b1;
          wr_addr  <= addr_cnt;
          wr_data  <= s ? '0 : bar_color(bar);
          addr_cnt <= addr_cnt + 1'b1;
          if (x == X_LAST) begin
            x   <= '0;
            bar <= '0;
            col <= '0;
            if (y == Y_LAST) begin
              issued_all <= 1'b1;
            end else begin
              y <= y + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
            if (col == C_LAST) begin
              col <= '0;
              bar <= bar + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end else begin
          wr_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fill_datapath.sv
// Directed testbench for fill_datapath with a 16x4 frame.
module tb_fill_datapath;

  localparam int H = 16;
  localparam int V = 4;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_counter;
  logic        y_reset;
  logic        s;
  logic        wr_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [11:0] wr_data;
  logic        f;

  int checks = 0;
  int errors = 0;

  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

  fill_datapath #(.H_RES(H), .V_RES(V), .ADDR_W(6), .COLOR_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .en_counter (en_counter),
    .y_reset    (y_reset),
    .s          (s),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .f          (f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic sel, input int a);
    int xi;
    xi = a % H;
    return sel ? 12'h000 : bars[xi / 2];
  endfunction

  // Called at a negedge. mode 0: wr_ready always 1; mode 1: 1,0,0,1 repeating.
  // Returns at stop_at (write shown, not yet accepted) or after f is checked.
  task automatic run_frame(input logic sel, input int mode, input int start,
                           input int stop_at, input int exp_cycles);
    int nxt;
    int cyc;
    int phase;
    logic held;
    logic rdy;
    logic [5:0]  hold_a;
    logic [11:0] hold_d;
    bit done;
    nxt = start; cyc = 0; phase = 0; held = 1'b0; done = 0;
    hold_a = '0; hold_d = '0;
    s = sel;
    en_counter = 1'b1;
    while (!done && cyc < 400) begin
      if (held) begin
        chk("hold_en", 32'(wr_en), 32'd1);
        chk("hold_addr", 32'(wr_addr), 32'(hold_a));
        chk("hold_data", 32'(wr_data), 32'(hold_d));
      end else if (wr_en) begin
        chk("addr_order", 32'(wr_addr), 32'(nxt));
        chk("data", 32'(wr_data), 32'(model(sel, nxt)));
      end
      if (wr_en && stop_at >= 0 && int'(wr_addr) == stop_at) begin
        done = 1;
      end else begin
        rdy = (mode == 0) ? 1'b1 : ((phase % 4) == 0 || (phase % 4) == 3);
        phase++;
        wr_ready = rdy;
        if (wr_en && rdy) begin
          nxt++;
          held = 1'b0;
        end else begin
          held = wr_en;
          hold_a = wr_addr;
          hold_d = wr_data;
        end
        @(negedge clk);
        cyc++;
        if (nxt == N) begin
          chk("f_set", 32'(f), 32'd1);
          chk("no_write_after_last", 32'(wr_en), 32'd0);
          if (exp_cycles > 0) chk("frame_cycles", cyc, exp_cycles);
          repeat (3) begin
            @(negedge clk);
            chk("f_hold", 32'(f), 32'd1);
            chk("no_65th_write", 32'(wr_en), 32'd0);
          end
          done = 1;
        end
      end
    end
    if (!done) chk("timeout_pixels", nxt, N);
  endtask

  // One-cycle y_reset pulse with en_counter high; leaves the bench at a negedge.
  task automatic pulse_y_reset();
    y_reset = 1'b1;
    en_counter = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    chk("yreset_f", 32'(f), 32'd0);
    chk("yreset_wr_en", 32'(wr_en), 32'd0);
    y_reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en_counter = 1'b0; y_reset = 1'b0; s = 1'b0; wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    reset = 1'b0;

    // Colour bars, back-to-back: 64 writes, f after H*V+1 cycles.
    run_frame(1'b0, 0, 0, -1, N + 1);

    // Restart after f, then stalled writes with ready pattern 1,0,0,1.
    pulse_y_reset();
    run_frame(1'b0, 1, 0, -1, 0);

    // Black clear frame.
    pulse_y_reset();
    run_frame(1'b1, 0, 0, -1, N + 1);

    // Pause at addr 20 with the write pending; s changes must not touch it.
    pulse_y_reset();
    run_frame(1'b0, 0, 0, 20, 0);
    wr_ready = 1'b0; en_counter = 1'b0; s = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("pause_wr_en", 32'(wr_en), 32'd1);
      chk("pause_addr", 32'(wr_addr), 32'd20);
      chk("pause_data", 32'(wr_data), 32'(model(1'b0, 20)));
    end
    wr_ready = 1'b1; s = 1'b0;
    @(negedge clk);
    chk("pause_accepted", 32'(wr_en), 32'd0);
    @(negedge clk);
    chk("pause_no_issue", 32'(wr_en), 32'd0);
    run_frame(1'b0, 0, 21, -1, 0);

    // y_reset while addr 37 is being accepted: write dropped, restart at 0.
    pulse_y_reset();
    run_frame(1'b0, 0, 0, 37, 0);
    y_reset = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    chk("drop_wr_en", 32'(wr_en), 32'd0);
    chk("drop_f", 32'(f), 32'd0);
    y_reset = 1'b0;
    @(negedge clk);
    chk("restart_wr_en", 32'(wr_en), 32'd1);
    chk("restart_addr", 32'(wr_addr), 32'd0);
    chk("restart_data", 32'(wr_data), 32'hFFF);
    run_frame(1'b0, 0, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
